// File: rtl/warp_issue_scheduler_pkg.sv
// Shared GPU front-end definitions: default warp count, warp-id width,
// default memory credit budget and the per-warp branch-wait state encoding.
package gpu_pkg;

  localparam int NUM_WARPS_DEF   = 8;
  localparam int WARP_ID_W       = $clog2(NUM_WARPS_DEF);
  localparam int MEM_CREDITS_DEF = 4;

  // A warp is either free to issue or parked behind an unresolved branch.
  typedef enum logic [0:0] {
    WARP_READY   = 1'b0,
    WARP_BR_WAIT = 1'b1
  } warp_state_e;

  // Width of a warp-id field for an arbitrary warp count (at least one bit).
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/warp_issue_scheduler_if.sv
// Issue-stage bundle between IBuffer/scoreboard/operand-collector side
// (master) and the warp issue scheduler (slave).
interface warp_issue_if
  import gpu_pkg::*;
#(
  parameter int NUM_WARPS = NUM_WARPS_DEF
);
  localparam int WID_W = id_width(NUM_WARPS);

  logic [NUM_WARPS-1:0] Valid_IB_IU;
  logic [NUM_WARPS-1:0] Is_Branch_IB_IU;
  logic [NUM_WARPS-1:0] Is_Mem_IB_IU;
  logic [NUM_WARPS-1:0] Full_Scb_IU;
  logic [NUM_WARPS-1:0] Dependent_Scb_IU;
  logic                 Stall_OC_IU;
  logic                 Br_Resolve_Valid;
  logic [WID_W-1:0]     Br_Resolve_WarpID;
  logic                 Mem_Credit_Return;
  logic [NUM_WARPS-1:0] Grant_IU;
  logic                 Grant_Valid;
  logic [WID_W-1:0]     Grant_WarpID;
  logic [NUM_WARPS-1:0] Br_Pending;
  logic                 Credit_Err;

  modport master (
    output Valid_IB_IU, Is_Branch_IB_IU, Is_Mem_IB_IU, Full_Scb_IU,
           Dependent_Scb_IU, Stall_OC_IU, Br_Resolve_Valid,
           Br_Resolve_WarpID, Mem_Credit_Return,
    input  Grant_IU, Grant_Valid, Grant_WarpID, Br_Pending, Credit_Err
  );

  modport slave (
    input  Valid_IB_IU, Is_Branch_IB_IU, Is_Mem_IB_IU, Full_Scb_IU,
           Dependent_Scb_IU, Stall_OC_IU, Br_Resolve_Valid,
           Br_Resolve_WarpID, Mem_Credit_Return,
    output Grant_IU, Grant_Valid, Grant_WarpID, Br_Pending, Credit_Err
  );

endinterface

// File: rtl/warp_issue_scheduler_rr_arbiter.sv
// Rotating-priority arbiter: picks the first requester at or after ptr
// (ascending, wrapping), returning a one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int ID_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [WIDTH-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_vld
);

  // Scan WIDTH positions starting at ptr; the first requester seen wins.
  always_comb begin
    int          raw;
    logic [ID_W-1:0] sel;
    logic        hit;
    gnt     = '0;
    gnt_id  = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      raw      = int'(ptr) + i;
      sel      = (raw >= WIDTH) ? ID_W'(raw - WIDTH) : ID_W'(raw);
      hit      = ~gnt_vld & req[sel];
      gnt[sel] = hit;
      gnt_id   = hit ? sel : gnt_id;
      gnt_vld  = gnt_vld | hit;
    end
  end

endmodule

// File: rtl/warp_issue_scheduler.sv
// Warp issue scheduler: picks at most one eligible warp per cycle
// (combinational grant), tracks per-warp branch-wait state and a shared
// memory-instruction credit pool.
// Optional build macro ISSUE_GREEDY_EN: the previously granted warp keeps
// winning while it stays eligible; otherwise strict round-robin.
module warp_issue_scheduler
  import gpu_pkg::*;
#(
  parameter int NUM_WARPS   = NUM_WARPS_DEF,
  parameter int MEM_CREDITS = MEM_CREDITS_DEF
) (
  input logic         clk,
  input logic         rst,
  warp_issue_if.slave bus
);

  localparam int WID_W    = id_width(NUM_WARPS);
  localparam int CREDIT_W = $clog2(MEM_CREDITS + 1);
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(MEM_CREDITS);
  localparam logic [CREDIT_W-1:0] CREDIT_ONE = CREDIT_W'(1);
  localparam logic [WID_W-1:0]    LAST_WARP  = WID_W'(NUM_WARPS - 1);
  localparam logic [WID_W-1:0]    ID_ONE     = WID_W'(1);

  warp_state_e          state      [NUM_WARPS];
  warp_state_e          state_next [NUM_WARPS];
  logic [WID_W-1:0]     rr_ptr, rr_ptr_next;
  logic [CREDIT_W-1:0]  credits, credits_next;
  logic                 credit_err, credit_err_next;
  logic [NUM_WARPS-1:0] br_pending;
  logic [NUM_WARPS-1:0] eligible;
  logic [NUM_WARPS-1:0] issue_req;
  logic [NUM_WARPS-1:0] arb_gnt;
  logic [WID_W-1:0]     arb_id;
  logic                 arb_vld;
  logic [NUM_WARPS-1:0] grant;
  logic [WID_W-1:0]     grant_id;
  logic                 grant_vld;
  logic                 rr_update;
  logic                 issue_ok;
  logic                 credits_empty;
  logic                 mem_issue;

  // Decode the registered warp states into the branch-wait mask.
  always_comb begin
    br_pending = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      br_pending[w] = (state[w] == WARP_BR_WAIT);
    end
  end

  // Eligibility; nothing may issue while in reset or when the collector stalls.
  always_comb begin
    credits_empty = (credits == '0);
    issue_ok      = rst & ~bus.Stall_OC_IU;
    eligible      = bus.Valid_IB_IU & ~bus.Full_Scb_IU & ~bus.Dependent_Scb_IU
                  & ~br_pending & ~(bus.Is_Mem_IB_IU & {NUM_WARPS{credits_empty}});
    issue_req     = issue_ok ? eligible : '0;
  end

  rr_arbiter #(
    .WIDTH (NUM_WARPS),
    .ID_W  (WID_W)
  ) u_rr_arbiter (
    .req     (issue_req),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_id  (arb_id),
    .gnt_vld (arb_vld)
  );

`ifdef ISSUE_GREEDY_EN
  logic [WID_W-1:0] last_id;
  logic             last_vld;
  logic             greedy_hit;

  // Last winner keeps the slot while still eligible; round-robin otherwise.
  always_comb begin
    greedy_hit = last_vld & issue_req[last_id];
    if (greedy_hit) begin
      grant          = '0;
      grant[last_id] = 1'b1;
      grant_id       = last_id;
      grant_vld      = 1'b1;
    end else begin
      grant     = arb_gnt;
      grant_id  = arb_id;
      grant_vld = arb_vld;
    end
    rr_update = grant_vld & ~greedy_hit;
  end

  // Remember the most recent winner across idle and stalled cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_id  <= '0;
      last_vld <= 1'b0;
    end else if (grant_vld) begin
      last_id  <= grant_id;
      last_vld <= 1'b1;
    end else begin
      last_id  <= last_id;
      last_vld <= last_vld;
    end
  end
`else
  // Strict round-robin: the arbiter result is the grant.
  always_comb begin
    grant     = arb_gnt;
    grant_id  = arb_id;
    grant_vld = arb_vld;
    rr_update = arb_vld;
  end
`endif

  // Advance the search pointer past the round-robin winner, else hold.
  always_comb begin
    if (rr_update) begin
      rr_ptr_next = (grant_id == LAST_WARP) ? '0 : grant_id + ID_ONE;
    end else begin
      rr_ptr_next = rr_ptr;
    end
  end

  // Credit pool: issue takes one, return gives one, both together cancel;
  // a return with the pool already full is dropped and flagged.
  always_comb begin
    credits_next    = credits;
    credit_err_next = 1'b0;
    mem_issue       = grant_vld & bus.Is_Mem_IB_IU[grant_id];
    case ({mem_issue, bus.Mem_Credit_Return})
      2'b10: credits_next = credits - CREDIT_ONE;
      2'b01: begin
        if (credits == CREDIT_MAX) begin
          credit_err_next = 1'b1;
        end else begin
          credits_next = credits + CREDIT_ONE;
        end
      end
      default: credits_next = credits;
    endcase
  end

  // Per-warp branch FSM: park on a granted branch, release on its resolve.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      state_next[w] = state[w];
      case (state[w])
        WARP_READY: begin
          if (grant[w] && bus.Is_Branch_IB_IU[w]) begin
            state_next[w] = WARP_BR_WAIT;
          end else begin
            state_next[w] = WARP_READY;
          end
        end
        WARP_BR_WAIT: begin
          if (bus.Br_Resolve_Valid && (bus.Br_Resolve_WarpID == WID_W'(w))) begin
            state_next[w] = WARP_READY;
          end else begin
            state_next[w] = WARP_BR_WAIT;
          end
        end
        default: state_next[w] = WARP_READY;
      endcase
    end
  end

  // Warp state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        state[w] <= WARP_READY;
      end
    end else begin
      state <= state_next;
    end
  end

  // Pointer, credit pool and error pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr     <= '0;
      credits    <= CREDIT_MAX;
      credit_err <= 1'b0;
    end else begin
      rr_ptr     <= rr_ptr_next;
      credits    <= credits_next;
      credit_err <= credit_err_next;
    end
  end

  assign bus.Grant_IU     = grant;
  assign bus.Grant_Valid  = grant_vld;
  assign bus.Grant_WarpID = grant_id;
  assign bus.Br_Pending   = br_pending;
  assign bus.Credit_Err   = credit_err;

endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Directed self-checking bench for warp_issue_scheduler.
// Inputs change just after a rising edge; outputs are sampled on the
// falling edge. Build with ISSUE_GREEDY_EN to run the greedy scenario.
module tb_warp_issue_scheduler;
  import gpu_pkg::*;

  localparam int NW = 8;

  logic clk;
  logic rst;
  int   chk_cnt;
  int   pass_cnt;

  warp_issue_if #(.NUM_WARPS(NW)) bus ();

  warp_issue_scheduler #(
    .NUM_WARPS   (NW),
    .MEM_CREDITS (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.Valid_IB_IU       = '0;
    bus.Is_Branch_IB_IU   = '0;
    bus.Is_Mem_IB_IU      = '0;
    bus.Full_Scb_IU       = '0;
    bus.Dependent_Scb_IU  = '0;
    bus.Stall_OC_IU       = 1'b0;
    bus.Br_Resolve_Valid  = 1'b0;
    bus.Br_Resolve_WarpID = 3'd0;
    bus.Mem_Credit_Return = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    bus.Valid_IB_IU = 8'hFF;
    sample();
    chk_cnt++;
    if (bus.Grant_IU !== 8'h00) $display("FAIL reset_grant got=%b exp=%b", bus.Grant_IU, 8'h00);
    else pass_cnt++;
    chk_cnt++;
    if ({bus.Grant_Valid, bus.Grant_WarpID} !== 4'h0) $display("FAIL reset_gvalid_id got=%b exp=%b", {bus.Grant_Valid, bus.Grant_WarpID}, 4'h0);
    else pass_cnt++;
    chk_cnt++;
    if ({bus.Br_Pending, bus.Credit_Err} !== 9'h000) $display("FAIL reset_pend_err got=%b exp=%b", {bus.Br_Pending, bus.Credit_Err}, 9'h000);
    else pass_cnt++;
    step();
    rst = 1'b1;
    bus.Valid_IB_IU = 8'h00;
    sample();
    chk_cnt++;
    if (bus.Grant_Valid !== 1'b0) $display("FAIL post_reset_idle got=%b exp=%b", bus.Grant_Valid, 1'b0);
    else pass_cnt++;
    bus.Valid_IB_IU = 8'h10;
    #1;
    chk_cnt++;
    if (bus.Grant_WarpID !== 3'd4 || bus.Grant_IU !== 8'h10) $display("FAIL post_reset_first got=%0d/%b exp=4/%b", bus.Grant_WarpID, bus.Grant_IU, 8'h10);
    else pass_cnt++;
    step();
  endtask

  task automatic test_round_robin();
    logic [NW-1:0] exp;
    do_reset();
    bus.Valid_IB_IU = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      exp = '0;
      exp[i % NW] = 1'b1;
      sample();
      chk_cnt++;
      if (bus.Grant_IU !== exp || bus.Grant_WarpID !== 3'(i % NW))
        $display("FAIL rr_order cyc=%0d got=%b/%0d exp=%b/%0d", i, bus.Grant_IU, bus.Grant_WarpID, exp, i % NW);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_branch();
    do_reset();
    bus.Valid_IB_IU     = 8'h08;
    bus.Is_Branch_IB_IU = 8'h08;
    sample();
    chk_cnt++;
    if (bus.Grant_IU !== 8'h08) $display("FAIL br_issue got=%b exp=%b", bus.Grant_IU, 8'h08);
    else pass_cnt++;
    step();
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) begin
        bus.Br_Resolve_Valid  = 1'b1;
        bus.Br_Resolve_WarpID = 3'd3;
      end
      sample();
      chk_cnt++;
      if (bus.Grant_Valid !== 1'b0 || bus.Br_Pending !== 8'h08)
        $display("FAIL br_wait cyc=%0d got=%b/%b exp=0/%b", c, bus.Grant_Valid, bus.Br_Pending, 8'h08);
      else pass_cnt++;
      step();
    end
    bus.Is_Branch_IB_IU   = 8'h00;
    bus.Br_Resolve_WarpID = 3'd5;
    sample();
    chk_cnt++;
    if (bus.Grant_IU !== 8'h08 || bus.Br_Pending !== 8'h00)
      $display("FAIL br_release got=%b/%b exp=%b/%b", bus.Grant_IU, bus.Br_Pending, 8'h08, 8'h00);
    else pass_cnt++;
    step();
    bus.Br_Resolve_Valid = 1'b0;
    sample();
    chk_cnt++;
    if (bus.Br_Pending !== 8'h00) $display("FAIL br_stray_resolve got=%b exp=%b", bus.Br_Pending, 8'h00);
    else pass_cnt++;
    step();
  endtask

  task automatic test_credits();
    do_reset();
    bus.Valid_IB_IU  = 8'h1F;
    bus.Is_Mem_IB_IU = 8'h1F;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk_cnt++;
      if (bus.Grant_Valid !== 1'b1 || bus.Grant_WarpID !== 3'(i))
        $display("FAIL mem_issue cyc=%0d got=%b/%0d exp=1/%0d", i, bus.Grant_Valid, bus.Grant_WarpID, i);
      else pass_cnt++;
      step();
      bus.Valid_IB_IU[i] = 1'b0;
    end
    for (int c = 0; c < 3; c++) begin
      if (c == 2) bus.Mem_Credit_Return = 1'b1;
      sample();
      chk_cnt++;
      if (bus.Grant_Valid !== 1'b0) $display("FAIL mem_blocked cyc=%0d got=%b exp=%b", c, bus.Grant_Valid, 1'b0);
      else pass_cnt++;
      step();
    end
    bus.Mem_Credit_Return = 1'b0;
    sample();
    chk_cnt++;
    if (bus.Grant_IU !== 8'h10) $display("FAIL mem_unblock got=%b exp=%b", bus.Grant_IU, 8'h10);
    else pass_cnt++;
    step();
  endtask

  task automatic test_credit_edges();
    int n;
    do_reset();
    bus.Mem_Credit_Return = 1'b1;
    sample();
    chk_cnt++;
    if (bus.Credit_Err !== 1'b0) $display("FAIL cerr_before got=%b exp=%b", bus.Credit_Err, 1'b0);
    else pass_cnt++;
    step();
    bus.Mem_Credit_Return = 1'b0;
    sample();
    chk_cnt++;
    if (bus.Credit_Err !== 1'b1) $display("FAIL cerr_pulse got=%b exp=%b", bus.Credit_Err, 1'b1);
    else pass_cnt++;
    step();
    sample();
    chk_cnt++;
    if (bus.Credit_Err !== 1'b0) $display("FAIL cerr_one_cycle got=%b exp=%b", bus.Credit_Err, 1'b0);
    else pass_cnt++;
    step();
    bus.Valid_IB_IU  = 8'h01;
    bus.Is_Mem_IB_IU = 8'h01;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      sample();
      if (bus.Grant_Valid === 1'b1) n++;
      step();
    end
    chk_cnt++;
    if (n !== 4) $display("FAIL cerr_saturate grants=%0d exp=%0d", n, 4);
    else pass_cnt++;

    do_reset();
    bus.Valid_IB_IU  = 8'h01;
    bus.Is_Mem_IB_IU = 8'h01;
    step();
    step();
    bus.Mem_Credit_Return = 1'b1;
    sample();
    chk_cnt++;
    if (bus.Grant_Valid !== 1'b1) $display("FAIL simul_grant got=%b exp=%b", bus.Grant_Valid, 1'b1);
    else pass_cnt++;
    step();
    bus.Mem_Credit_Return = 1'b0;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      sample();
      if (c == 0) begin
        chk_cnt++;
        if (bus.Credit_Err !== 1'b0) $display("FAIL simul_no_err got=%b exp=%b", bus.Credit_Err, 1'b0);
        else pass_cnt++;
      end
      if (bus.Grant_Valid === 1'b1) n++;
      step();
    end
    chk_cnt++;
    if (n !== 2) $display("FAIL simul_credits grants=%0d exp=%0d", n, 2);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    do_reset();
    bus.Valid_IB_IU = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      sample();
      chk_cnt++;
      if (bus.Grant_WarpID !== 3'(i)) $display("FAIL stall_pre cyc=%0d got=%0d exp=%0d", i, bus.Grant_WarpID, i);
      else pass_cnt++;
      step();
    end
    bus.Stall_OC_IU = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample();
      chk_cnt++;
      if (bus.Grant_IU !== 8'h00 || bus.Grant_Valid !== 1'b0 || bus.Grant_WarpID !== 3'd0)
        $display("FAIL stall_hold cyc=%0d got=%b/%b/%0d exp=%b/0/0", c, bus.Grant_IU, bus.Grant_Valid, bus.Grant_WarpID, 8'h00);
      else pass_cnt++;
      step();
    end
    bus.Stall_OC_IU = 1'b0;
    sample();
    chk_cnt++;
    if (bus.Grant_IU !== 8'h04) $display("FAIL stall_resume got=%b exp=%b", bus.Grant_IU, 8'h04);
    else pass_cnt++;
    step();
  endtask

  task automatic test_branch_mem();
    int n;
    do_reset();
    bus.Valid_IB_IU     = 8'h01;
    bus.Is_Branch_IB_IU = 8'h01;
    bus.Is_Mem_IB_IU    = 8'h01;
    sample();
    chk_cnt++;
    if (bus.Grant_IU !== 8'h01) $display("FAIL brmem_issue got=%b exp=%b", bus.Grant_IU, 8'h01);
    else pass_cnt++;
    step();
    sample();
    chk_cnt++;
    if (bus.Br_Pending !== 8'h01) $display("FAIL brmem_pending got=%b exp=%b", bus.Br_Pending, 8'h01);
    else pass_cnt++;
    step();
    bus.Br_Resolve_Valid  = 1'b1;
    bus.Br_Resolve_WarpID = 3'd0;
    bus.Is_Branch_IB_IU   = 8'h00;
    step();
    bus.Br_Resolve_Valid = 1'b0;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      sample();
      if (bus.Grant_Valid === 1'b1) n++;
      step();
    end
    chk_cnt++;
    if (n !== 3) $display("FAIL brmem_credit grants=%0d exp=%0d", n, 3);
    else pass_cnt++;

    do_reset();
    bus.Valid_IB_IU     = 8'h01;
    bus.Is_Branch_IB_IU = 8'h01;
    bus.Is_Mem_IB_IU    = 8'h01;
    step();
    rst = 1'b0;
    sample();
    chk_cnt++;
    if (bus.Br_Pending !== 8'h00 || bus.Grant_Valid !== 1'b0)
      $display("FAIL midreset_clear got=%b/%b exp=%b/0", bus.Br_Pending, bus.Grant_Valid, 8'h00);
    else pass_cnt++;
    step();
    rst = 1'b1;
    bus.Is_Branch_IB_IU = 8'h00;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      sample();
      if (bus.Grant_Valid === 1'b1) n++;
      step();
    end
    chk_cnt++;
    if (n !== 4) $display("FAIL midreset_credits grants=%0d exp=%0d", n, 4);
    else pass_cnt++;
  endtask

`ifdef ISSUE_GREEDY_EN
  task automatic test_greedy();
    do_reset();
    bus.Valid_IB_IU = 8'h20;
    sample();
    chk_cnt++;
    if (bus.Grant_WarpID !== 3'd5) $display("FAIL greedy_seed got=%0d exp=%0d", bus.Grant_WarpID, 5);
    else pass_cnt++;
    step();
    bus.Valid_IB_IU = 8'h24;
    for (int c = 0; c < 3; c++) begin
      sample();
      chk_cnt++;
      if (bus.Grant_IU !== 8'h20) $display("FAIL greedy_hold cyc=%0d got=%b exp=%b", c, bus.Grant_IU, 8'h20);
      else pass_cnt++;
      step();
    end
    bus.Dependent_Scb_IU = 8'h20;
    sample();
    chk_cnt++;
    if (bus.Grant_IU !== 8'h04) $display("FAIL greedy_fallback got=%b exp=%b", bus.Grant_IU, 8'h04);
    else pass_cnt++;
    step();
  endtask
`endif

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    rst      = 1'b0;
    clear_inputs();
    test_reset();
`ifdef ISSUE_GREEDY_EN
    test_greedy();
`else
    test_round_robin();
    test_stall();
`endif
    test_branch();
    test_credits();
    test_credit_edges();
    test_branch_mem();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/warp_issue_scheduler.md
WARP_ISSUE_SCHEDULER -- requirements
Module: warp_issue_scheduler

Interface
REQ-001 SHALL have parameter NUM_WARPS, 8, number of warps arbitrated.
REQ-002 SHALL have parameter MEM_CREDITS, 4, outstanding memory instructions allowed in flight.
REQ-003 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Valid_IB_IU  input  NUM_WARPS  per-warp instruction present at IBuffer head.
REQ-006 SHALL have port Is_Branch_IB_IU  input  NUM_WARPS  per-warp head instruction is a branch.
REQ-007 SHALL have port Is_Mem_IB_IU  input  NUM_WARPS  per-warp head instruction is LW/SW.
REQ-008 SHALL have port Full_Scb_IU  input  NUM_WARPS  per-warp scoreboard full.
REQ-009 SHALL have port Dependent_Scb_IU  input  NUM_WARPS  per-warp hazard against pending entries.
REQ-010 SHALL have port Stall_OC_IU  input  1  operand collector cannot accept an instruction this cycle.
REQ-011 SHALL have port Br_Resolve_Valid  input  1  ALU resolved a branch.
REQ-012 SHALL have port Br_Resolve_WarpID  input  WARP_ID_W  warp whose branch resolved.
REQ-013 SHALL have port Mem_Credit_Return  input  1  one memory instruction retired.
REQ-014 SHALL have port Grant_IU  output  NUM_WARPS  one-hot issue grant (drives scoreboard issue_grant and IBuffer pop).
REQ-015 SHALL have port Grant_Valid  output  1  OR of Grant_IU.
REQ-016 SHALL have port Grant_WarpID  output  WARP_ID_W  encoded granted warp; 0 when Grant_Valid=0.
REQ-017 SHALL have port Br_Pending  output  NUM_WARPS  per-warp branch-wait state.
REQ-018 SHALL have port Credit_Err  output  1  one-cycle pulse on credit return at MEM_CREDITS.

Function
REQ-019 Warp w eligible SHALL be: Valid&~Full&~Dependent&~Br_Pending[w]&~(Is_Mem[w]&credits==0), all evaluated same cycle.
REQ-020 Grant SHALL be combinational from registered state and current inputs (zero-cycle latency); at most one bit of Grant_IU set.
REQ-021 When Stall_OC_IU=1 SHALL drive Grant_IU=0; pointer, credits, Br_Pending unchanged by issue.
REQ-022 Round-robin: search eligible warps starting at rr_ptr, ascending, wrapping NUM_WARPS-1 -> 0; on grant rr_ptr <= (granted+1) mod NUM_WARPS; no grant -> rr_ptr holds.
REQ-023 Per-warp FSM READY -> BR_WAIT on grant of a branch; BR_WAIT -> READY on edge where Br_Resolve_Valid and Br_Resolve_WarpID==w; resolve not bypassed (warp eligible the cycle after).
REQ-024 Resolve for a warp in READY SHALL be ignored (no state change).
REQ-025 Credit counter width clog2(MEM_CREDITS+1); grant of mem instr decrements; Mem_Credit_Return increments; both same cycle -> unchanged.
REQ-026 Return at credits==MEM_CREDITS (no simultaneous mem grant) SHALL saturate and pulse Credit_Err next cycle; return not bypassed when credits==0.
REQ-027 Branch-and-mem flags both set: both effects apply.

Reset
REQ-028 On rst=0: rr_ptr=0, credits=MEM_CREDITS, all warps READY, Credit_Err=0; Grant_IU=0 while rst asserted.
REQ-029 Reset mid-operation SHALL discard pending branches/credits; no grant on first cycle after deassertion unless eligible per REQ-019.

Configuration
REQ-030 Macro ISSUE_GREEDY_EN defined: if last granted warp (registered last_id, last_vld) is eligible it SHALL win, else round-robin from rr_ptr; rr_ptr updates only on non-greedy grants.
REQ-031 Macro undefined: strict round-robin per REQ-022; no last_id state.

Structure
REQ-032 Shared package gpu_pkg SHALL hold NUM_WARPS default, WARP_ID_W=$clog2(NUM_WARPS), MEM_CREDITS default, warp FSM state enum.
REQ-033 One sub-module rr_arbiter (rotating-priority one-hot select + encode, parameterised by width) SHALL be instantiated.

Verification
REQ-034 All 8 warps eligible 9 cycles, no stall -> grants 0,1,...,7,0 (greedy off).
REQ-035 Warp 3 branch granted; Br_Resolve warp 3 in cycle 5 -> warp 3 not granted cycles 1-5, eligible cycle 6, Br_Pending[3] 1->0.
REQ-036 Five back-to-back mem instrs warps 0-4, no returns -> four grants, warp 4 blocked until one Mem_Credit_Return.
REQ-037 Return at credits=4 -> credits stays 4, Credit_Err high one cycle; simultaneous grant+return at credits=2 -> stays 2.
REQ-038 Stall_OC_IU=1 for 3 cycles with warps eligible -> Grant_IU=0, rr_ptr held; resumes at same warp.
REQ-039 ISSUE_GREEDY_EN, warps 2 and 5 eligible, last=5 -> warp 5 granted repeatedly until Dependent[5]=1, then warp 2.
